top: RTL and testbench
======================

# top

Push-button conditioning block: synchronises a bouncy mechanical input, filters it with a stability counter, and emits a one-cycle pulse on each qualifying edge of the cleaned signal. It sits directly behind a board-level button pin and feeds control logic that needs a clean level (`debounce`) and a single-cycle event strobe (`edges`).

## Interface
- `DEBOUNCE_CYCLES`, default 200_000: consecutive clock cycles the synchronised input must hold a new level before `debounce` follows it (2 ms at 100 MHz). Legal range is 2 to 2^24.
- `clk`, input, 1 bit: single clock, nominally 100 MHz; all state changes on its rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `noisy`, input, 1 bit: raw button level, asynchronous to `clk`, may bounce.
- `debounce`, output, 1 bit: filtered, registered button level.
- `edges`, output, 1 bit: one-cycle event pulse derived from `debounce`.

## Operation
- Synchroniser: two flops, `s1 <= noisy`, `s2 <= s1`. Both reset to 0.
- Counter: width ceil(log2(DEBOUNCE_CYCLES)), reset 0.
  - If `s2 == debounce`, the counter clears to 0.
  - If `s2 != debounce` and the counter is below `DEBOUNCE_CYCLES-1`, the counter increments.
  - If `s2 != debounce` and the counter equals `DEBOUNCE_CYCLES-1`, then `debounce <= s2` and the counter clears.
- A mismatch that ends before the terminal count (any bounce) discards the accumulated count. No partial credit carries over.
- Edge detector: register `deb_d <= debounce`, reset 0.
- Rising-edge term: `debounce & ~deb_d`.
- Falling-edge term: `~debounce & deb_d`, used only when enabled (see Configuration).
- `edges` is combinational from `debounce` and `deb_d`. It is high exactly in the first cycle `debounce` holds its new value.
- Reset values: `debounce`=0, `edges`=0, counter=0, `s1`=`s2`=`deb_d`=0.
- Asserting reset mid-count aborts the count with no pulse. After release, an input already held high needs the full latency again.
- Counter saturation and wrap-around cannot occur, because the counter clears at the terminal count.

## Timing
- Number clock edges from edge 1, the first rising `clk` edge that samples a new `noisy` level.
  - `s1` updates at edge 1.
  - `s2` updates at edge 2.
  - `debounce` updates at edge `DEBOUNCE_CYCLES+2`.
- Total latency is `DEBOUNCE_CYCLES+2` cycles, provided `noisy` stays stable throughout.
- `edges` is high for exactly one cycle, from edge `DEBOUNCE_CYCLES+2` to the next edge.
- Input pulses or bounces shorter than `DEBOUNCE_CYCLES` cycles, as seen at `s2`, never reach `debounce` and produce no `edges` pulse.
- Minimum spacing between two `edges` pulses is `DEBOUNCE_CYCLES` cycles.
- Reset acts immediately on assertion, independent of `clk`. Release is expected synchronous to the board reset tree; no internal reset synchroniser.

## Configuration
- Macro `BOTH_EDGES_EN`.
  - Defined: `edges` pulses on both rising and falling transitions of `debounce`.
  - Undefined (default): `edges` pulses only on rising transitions (button press).
- The macro has no effect on `debounce` or on latency.

## Test plan
- Reset: hold `reset_n`=0 with `noisy`=1 -> `debounce`=0 and `edges`=0. Release -> `debounce` rises at edge `DEBOUNCE_CYCLES+2`, and `edges` is high for 1 cycle in that same cycle.
- Clean press and release, default parameter at 100 MHz: `noisy`=1 for 5 ms, then 0 for 5 ms.
  - `debounce` goes high 2.00002 ms after the rise and low 2.00002 ms after the fall.
  - Exactly one `edges` pulse without `BOTH_EDGES_EN`; two pulses with it.
- Bounce rejection: four alternating 1 ms segments (1,0,1,0), then `noisy`=1 for 5 ms.
  - `debounce` stays 0 through the 1 ms segments.
  - `debounce` rises 2 ms + 2 cycles into the 5 ms hold, with a single `edges` pulse.
- Release bounce: from `debounce`=1, apply 1 ms alternating 0/1 segments, then a final 0.
  - `debounce` falls only after the final 0 has been stable for `DEBOUNCE_CYCLES` cycles.
  - No rising `edges` pulse is generated by the bounce.
- Boundary, with `DEBOUNCE_CYCLES`=8:
  - A 7-cycle high pulse at `s2` gives no change.
  - An 8-cycle high pulse at `s2` sets `debounce`=1 at edge 10 counted from the input change.
- Mid-count reset, with `DEBOUNCE_CYCLES`=8: assert `reset_n`=0 for 1 cycle during cycle 5 of a qualifying pulse -> no `edges` pulse, and the count restarts from 0 after release.

Source files
------------

// File: rtl/top.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debounce, edge strobe.
// Define BOTH_EDGES_EN to pulse `edges` on falling as well as rising transitions.
module top #(
  parameter int unsigned DEBOUNCE_CYCLES = 200_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic debounce,
  output logic edges
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          debounce_q, debounce_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d       = noisy;
    s2_d       = s1_q;
    prev_d     = debounce_q;
    debounce_d = debounce_q;
    cnt_d      = '0;
    // Any agreement, including a bounce back, throws away the accumulated count.
    if (s2_q != debounce_q) begin
      if (cnt_q == TERM) begin
        debounce_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      debounce_q <= 1'b0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      debounce_q <= debounce_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
    end
  end

  assign debounce = debounce_q;

`ifdef BOTH_EDGES_EN
  assign edges = (debounce_q & ~prev_q) | (~debounce_q & prev_q);
`else
  assign edges = debounce_q & ~prev_q;
`endif

endmodule

// File: tb/tb_top.sv
// Scoreboarded bench for top with DEBOUNCE_CYCLES=8: directed scenarios then random segments.
module tb_top;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic noisy = 1'b0;
  logic debounce;
  logic edges;

  top #(.DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .noisy    (noisy),
    .debounce (debounce),
    .edges    (edges)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic deb;
    logic edg;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference: the level seen two samples late must disagree with the filtered
  // level for N consecutive samples before the filtered level adopts it.
  logic pipe[$];
  logic ref_level = 1'b0;
  int unsigned streak = 0;
  logic ref_pulse = 1'b0;

  function automatic void ref_reset();
    pipe = '{1'b0, 1'b0};
    ref_level = 1'b0;
    streak = 0;
    ref_pulse = 1'b0;
  endfunction

  function automatic void ref_sample(input logic raw);
    logic seen;
    seen = pipe.pop_front();
    pipe.push_back(raw);
    ref_pulse = 1'b0;
    if (seen != ref_level) begin
      streak++;
      if (streak == N) begin
        streak = 0;
        ref_level = seen;
`ifdef BOTH_EDGES_EN
        ref_pulse = 1'b1;
`else
        ref_pulse = seen;
`endif
      end
    end else begin
      streak = 0;
    end
  endfunction

  task automatic tick(input logic nv, input logic rv);
    @(posedge clk);
    #1;
    if (!rv) reset_n = 1'b0;
    if (!reset_n) ref_reset();
    else ref_sample(noisy);
    exp_q.push_back('{deb: ref_level, edg: ref_pulse});
    reset_n = rv;
    noisy = nv;
  endtask

  // Hold `level` for `len` cycles; pulse reset for one cycle at index rst_at (-1: none).
  task automatic seg(input logic level, input int len, input int rst_at);
    for (int i = 0; i < len; i++) tick(level, (i == rst_at) ? 1'b0 : 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (debounce === e.deb) passed++;
      else $display("FAIL debounce t=%0t got %b expected %b", $time, debounce, e.deb);
      checks++;
      if (edges === e.edg) passed++;
      else $display("FAIL edges t=%0t got %b expected %b", $time, edges, e.edg);
    end
  end

  initial begin
    ref_reset();
    // Reset held with button pressed, then release: rise at edge N+2.
    noisy = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    seg(1'b1, 20, -1);
    seg(1'b0, 20, -1);
    // Press bounce, then stable hold.
    seg(1'b1, 3, -1); seg(1'b0, 3, -1); seg(1'b1, 3, -1); seg(1'b0, 3, -1);
    seg(1'b1, 20, -1);
    // Release bounce, then stable low.
    seg(1'b0, 3, -1); seg(1'b1, 2, -1); seg(1'b0, 3, -1); seg(1'b1, 1, -1);
    seg(1'b0, 20, -1);
    // Boundary pulses: N-1 is rejected, N is accepted.
    seg(1'b1, N - 1, -1); seg(1'b0, 15, -1);
    seg(1'b1, N, -1);     seg(1'b0, 20, -1);
    // Mid-count reset aborts the count; a full period is needed afterwards.
    seg(1'b1, 14, 5);     seg(1'b1, 6, -1);
    seg(1'b0, 20, -1);
    // Random segments around the threshold.
    for (int k = 0; k < 300; k++) begin
      logic lv;
      int ln;
      lv = 1'($urandom_range(0, 1));
      ln = int'($urandom_range(1, 2 * N + 2));
      seg(lv, ln, ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, ln - 1)) : -1);
    end
    seg(1'b0, 4, -1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
